lsq_ooo_buffer: RTL and testbench
=================================

Name: lsq_ooo_buffer

Overview:
- Parametrised successor load/store queue between issue, ROB, the two result buses and the memory controller.
- FIFO-ordered, operand snooping, loads optionally execute before commit (non-IO only).
- Committed stores survive a pipeline flush and drain to memory.
- Correct load sign/zero extension.

Parameters:
- DEPTH, 16, entry count (power of 2, >=2).
- ROB_W, 4, ROB index width; tag 0 reserved = "operand ready".
- XLEN, 32, data/address width.
- LOAD_SPEC, 1, 1 = loads dispatch without waiting for commit.
- IO_BASE, 32'h00030000, addresses >= IO_BASE are IO; loads there always wait for commit.

Ports:
- clk_in in 1 clock
- rst_in in 1 synchronous active-high reset
- rdy_in in 1 global enable; low freezes all state
- clr_in in 1 misprediction flush
- issue_valid in 1 new entry
- issue_rob_index in ROB_W tag of the entry
- issue_is_store in 1 store flag
- issue_funct3 in 3 width/sign code
- issue_rs1_val, issue_rs2_val in XLEN operand values
- issue_rs1_dep, issue_rs2_dep in ROB_W producer tags (0 = valid)
- issue_imm in XLEN offset
- cdb0_valid in 1, cdb0_tag in ROB_W, cdb0_data in XLEN: ALU bus
- rob_commit_valid in 1, rob_commit_index in ROB_W: commit bus
- mc_req out 1, mc_we out 1, mc_len out 2 (01 B, 10 H, 11 W), mc_addr out XLEN, mc_wdata out XLEN
- mc_done in 1 access complete, mc_rdata in XLEN raw read data
- lsq_full out 1 no free entry
- res_valid out 1, res_data out XLEN, res_rob_index out ROB_W: load result, also cdb1

Behaviour:
- Reset/clear values: rst_in zeroes pointers, count, entry valid/committed bits, mc_req, mc_we, res_valid, res_data, res_rob_index, mc_addr, mc_wdata, mc_len. FSM goes to IDLE. rst_in overrides clr_in.
- rdy_in low: nothing changes; mc_done ignored.
- Storage: circular buffer, head/tail are log2(DEPTH) bits with natural wrap, plus a count register. All DEPTH entries are usable. lsq_full = (count==DEPTH), combinational.
- Issue: issue_valid && !lsq_full writes at tail; tail+1, count+1. issue_valid while full is ignored.
- Issue-cycle bypass: if an issuing dep tag matches cdb0 or res_valid in that cycle, capture the bus data with dep=0.
- Snoop: every cycle, each valid entry with dep==cdb0_tag (cdb0_valid), or dep==res_rob_index (res_valid), takes the data and clears dep. cdb0 has priority on an identical tag.
- Commit: rob_commit_valid sets committed on the entry whose rob_index matches. Commits arrive in program order, so committed entries form a prefix from head.
- Head eligible when valid, both deps 0, and:
  - store: committed.
  - load: committed, or (LOAD_SPEC && addr < IO_BASE).
- addr = rs1+imm, mod 2^XLEN.
- FSM IDLE: if head eligible, next cycle mc_req=1, mc_we=is_store, mc_addr, mc_wdata=rs2, mc_len from funct3[1:0] (00->01, 01->10, 10->11); go WAIT.
- FSM WAIT: hold all mc_* stable until mc_done.
  - Cycle after mc_done: mc_req=0, pop head, count-1, IDLE.
  - Load with drop=0: res_valid=1 for exactly one cycle with res_rob_index. funct3 000 sign-ext byte, 001 sign-ext half, 010 word, 100 zero-ext byte, 101 zero-ext half.
  - Stores never assert res_valid.
  - Minimum one idle cycle between accesses.
- Simultaneous issue and pop: count unchanged; full computed before update.
- Flush clr_in (no reset): keep only the committed-store prefix from head; clear the others' valid bits; tail = head + kept count.
  - Op in flight: stays in WAIT. A store completes normally. A load sets drop and on mc_done pops silently (no res_valid).
  - Issue in the clr_in cycle is discarded.
  - A same-cycle commit is applied before the keep decision.
- Entries never reorder; the head is the only dispatch point.

Decomposition:
- Shared package: funct3 encodings, len codes, IO_BASE default, ROB_W, reserved-tag-0 constant.
- Sub-module lsq_load_align: combinational funct3 + raw data -> extended result.

Test Plan:
- Load with LOAD_SPEC=1: issue LB rob3, rs1=0x100, imm=4, deps 0 -> mc_req, addr 0x104, len 01, no commit needed. mc_rdata=0x80 -> res_data 0xFFFFFF80, tag 3, single pulse.
- IO load: issue LW, rs1+imm=0x30004 -> no mc_req until commit rob index matches; then read; LHU of 0x8001 -> 0x00008001.
- Snoop/bypass: issue SW rs2_dep=5 in the same cycle cdb0 tag5 data 0xDEADBEEF. After commit -> mc_we=1, mc_wdata 0xDEADBEEF, len 11, res_valid never set.
- Full/wrap: issue 16 entries with no commit -> lsq_full=1, 17th ignored. Drain 3, issue 3 more -> wraps, order preserved in mc_addr sequence.
- Flush: two committed stores, one uncommitted load, in-flight spec load. clr_in -> both stores still written in order; dropped load never gives res_valid; count=stores.
- rdy_in low mid-WAIT with mc_done pulsed -> ignored, state frozen; resumes correctly once rdy_in rises and mc_done reasserts.

Source files
------------

// File: rtl/lsq_ooo_buffer_pkg.sv
// Shared encodings for the load/store queue: funct3 codes, memory length
// codes, defaults and the reserved "operand ready" tag.
package lsq_ooo_buffer_pkg;

  localparam int unsigned ROB_W_DEFAULT   = 4;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
  localparam int unsigned TAG_READY       = 0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] LEN_B = 2'b01;
  localparam logic [1:0] LEN_H = 2'b10;
  localparam logic [1:0] LEN_W = 2'b11;

  typedef enum logic {S_IDLE, S_WAIT} mem_state_t;

  // funct3[1:0] selects the access size presented to the memory controller
  function automatic logic [1:0] len_code(input logic [1:0] size);
    case (size)
      2'b00:   return LEN_B;
      2'b01:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/lsq_ooo_buffer_if.sv
// Issue, result-bus, commit, memory-controller and load-result signals of
// the load/store queue. slave = the queue, master = its environment.
interface lsq_ooo_buffer_if #(
  parameter int unsigned ROB_W = 4,
  parameter int unsigned XLEN  = 32
);
  logic             issue_valid;
  logic [ROB_W-1:0] issue_rob_index;
  logic             issue_is_store;
  logic [2:0]       issue_funct3;
  logic [XLEN-1:0]  issue_rs1_val;
  logic [XLEN-1:0]  issue_rs2_val;
  logic [ROB_W-1:0] issue_rs1_dep;
  logic [ROB_W-1:0] issue_rs2_dep;
  logic [XLEN-1:0]  issue_imm;
  logic             cdb0_valid;
  logic [ROB_W-1:0] cdb0_tag;
  logic [XLEN-1:0]  cdb0_data;
  logic             rob_commit_valid;
  logic [ROB_W-1:0] rob_commit_index;
  logic             mc_req;
  logic             mc_we;
  logic [1:0]       mc_len;
  logic [XLEN-1:0]  mc_addr;
  logic [XLEN-1:0]  mc_wdata;
  logic             mc_done;
  logic [XLEN-1:0]  mc_rdata;
  logic             lsq_full;
  logic             res_valid;
  logic [XLEN-1:0]  res_data;
  logic [ROB_W-1:0] res_rob_index;

  modport slave (
    input  issue_valid, issue_rob_index, issue_is_store, issue_funct3,
           issue_rs1_val, issue_rs2_val, issue_rs1_dep, issue_rs2_dep, issue_imm,
           cdb0_valid, cdb0_tag, cdb0_data, rob_commit_valid, rob_commit_index,
           mc_done, mc_rdata,
    output mc_req, mc_we, mc_len, mc_addr, mc_wdata, lsq_full,
           res_valid, res_data, res_rob_index
  );

  modport master (
    output issue_valid, issue_rob_index, issue_is_store, issue_funct3,
           issue_rs1_val, issue_rs2_val, issue_rs1_dep, issue_rs2_dep, issue_imm,
           cdb0_valid, cdb0_tag, cdb0_data, rob_commit_valid, rob_commit_index,
           mc_done, mc_rdata,
    input  mc_req, mc_we, mc_len, mc_addr, mc_wdata, lsq_full,
           res_valid, res_data, res_rob_index
  );
endinterface

// File: rtl/lsq_ooo_buffer_load_align.sv
// Load result extension: raw memory data plus funct3 -> register value.
module lsq_load_align
  import lsq_ooo_buffer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  // sign/zero extend the low byte or half according to funct3
  always_comb begin
    data = raw;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LH:   data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LW:   data = raw;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsq_ooo_buffer.sv
// In-order load/store queue: circular buffer with operand snooping, commit
// tracking, speculative non-IO loads and a single-access memory FSM.
module lsq_ooo_buffer
  import lsq_ooo_buffer_pkg::*;
#(
  parameter int unsigned     DEPTH     = 16,
  parameter int unsigned     ROB_W     = ROB_W_DEFAULT,
  parameter int unsigned     XLEN      = 32,
  parameter bit              LOAD_SPEC = 1'b1,
  parameter logic [XLEN-1:0] IO_BASE   = XLEN'(IO_BASE_DEFAULT)
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  input logic             clr_in,
  lsq_ooo_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [ROB_W-1:0] READY = ROB_W'(TAG_READY);

  logic [DEPTH-1:0] e_valid, e_commit, e_store;
  logic [2:0]       e_f3  [DEPTH];
  logic [ROB_W-1:0] e_rob [DEPTH];
  logic [ROB_W-1:0] e_d1  [DEPTH];
  logic [ROB_W-1:0] e_d2  [DEPTH];
  logic [XLEN-1:0]  e_rs1 [DEPTH];
  logic [XLEN-1:0]  e_rs2 [DEPTH];
  logic [XLEN-1:0]  e_imm [DEPTH];

  logic [AW-1:0] head, tail, idx;
  logic [CW-1:0] count, kept;
  logic [DEPTH-1:0] keep;
  mem_state_t    state;
  logic          drop, run, cmt;

  logic [XLEN-1:0]  iss_rs1, iss_rs2, h_addr, load_data;
  logic [ROB_W-1:0] iss_d1, iss_d2;
  logic issue_ok, pop, head_elig;

  assign bus.lsq_full = (count == CW'(DEPTH));
  assign issue_ok     = bus.issue_valid && !bus.lsq_full && !clr_in;
  assign pop          = (state == S_WAIT) && bus.mc_done;
  assign h_addr       = e_rs1[head] + e_imm[head];
  assign head_elig    = e_valid[head] && e_d1[head] == READY && e_d2[head] == READY &&
                        (e_commit[head] || (LOAD_SPEC && !e_store[head] && h_addr < IO_BASE));

  lsq_load_align #(.XLEN(XLEN)) u_align (
    .funct3(e_f3[head]),
    .raw   (bus.mc_rdata),
    .data  (load_data)
  );

  // issue-cycle bypass: operands produced on a result bus this cycle are captured directly
  always_comb begin
    iss_rs1 = bus.issue_rs1_val;
    iss_d1  = bus.issue_rs1_dep;
    iss_rs2 = bus.issue_rs2_val;
    iss_d2  = bus.issue_rs2_dep;
    if (iss_d1 != READY) begin
      if (bus.cdb0_valid && bus.cdb0_tag == iss_d1) begin
        iss_rs1 = bus.cdb0_data; iss_d1 = READY;
      end else if (bus.res_valid && bus.res_rob_index == iss_d1) begin
        iss_rs1 = bus.res_data; iss_d1 = READY;
      end
    end
    if (iss_d2 != READY) begin
      if (bus.cdb0_valid && bus.cdb0_tag == iss_d2) begin
        iss_rs2 = bus.cdb0_data; iss_d2 = READY;
      end else if (bus.res_valid && bus.res_rob_index == iss_d2) begin
        iss_rs2 = bus.res_data; iss_d2 = READY;
      end
    end
  end

  // flush survivor scan: the in-flight head entry plus the run of committed stores behind it;
  // keeping the in-flight entry lets its completion pop it like any other access
  always_comb begin
    keep = '0;
    kept = '0;
    run  = 1'b1;
    idx  = '0;
    cmt  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      cmt = e_commit[idx] || (bus.rob_commit_valid && e_rob[idx] == bus.rob_commit_index);
      if (run && e_valid[idx] && ((i == 0 && state == S_WAIT) || (cmt && e_store[idx]))) begin
        keep[idx] = 1'b1;
        kept      = kept + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // queue state, snooping, commit marking and the memory access FSM
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      e_valid           <= '0;
      e_commit          <= '0;
      state             <= S_IDLE;
      drop              <= 1'b0;
      bus.mc_req        <= 1'b0;
      bus.mc_we         <= 1'b0;
      bus.mc_len        <= '0;
      bus.mc_addr       <= '0;
      bus.mc_wdata      <= '0;
      bus.res_valid     <= 1'b0;
      bus.res_data      <= '0;
      bus.res_rob_index <= '0;
    end else if (rdy_in) begin
      bus.res_valid <= 1'b0;

      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (e_valid[AW'(i)]) begin
          if (e_d1[i] != READY) begin
            if (bus.cdb0_valid && e_d1[i] == bus.cdb0_tag) begin
              e_rs1[i] <= bus.cdb0_data; e_d1[i] <= READY;
            end else if (bus.res_valid && e_d1[i] == bus.res_rob_index) begin
              e_rs1[i] <= bus.res_data; e_d1[i] <= READY;
            end
          end
          if (e_d2[i] != READY) begin
            if (bus.cdb0_valid && e_d2[i] == bus.cdb0_tag) begin
              e_rs2[i] <= bus.cdb0_data; e_d2[i] <= READY;
            end else if (bus.res_valid && e_d2[i] == bus.res_rob_index) begin
              e_rs2[i] <= bus.res_data; e_d2[i] <= READY;
            end
          end
          if (bus.rob_commit_valid && e_rob[i] == bus.rob_commit_index)
            e_commit[AW'(i)] <= 1'b1;
        end
      end

      if (clr_in) begin
        e_valid <= keep;
        tail    <= head + kept[AW-1:0];
        count   <= kept - CW'(pop);
      end else begin
        if (issue_ok) begin
          e_valid[tail]  <= 1'b1;
          e_commit[tail] <= 1'b0;
          e_store[tail]  <= bus.issue_is_store;
          e_f3[tail]     <= bus.issue_funct3;
          e_rob[tail]    <= bus.issue_rob_index;
          e_rs1[tail]    <= iss_rs1;
          e_d1[tail]     <= iss_d1;
          e_rs2[tail]    <= iss_rs2;
          e_d2[tail]     <= iss_d2;
          e_imm[tail]    <= bus.issue_imm;
          tail           <= tail + 1'b1;
        end
        count <= count + CW'(issue_ok) - CW'(pop);
      end

      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (head_elig && !clr_in) begin
            state        <= S_WAIT;
            drop         <= 1'b0;
            bus.mc_req   <= 1'b1;
            bus.mc_we    <= e_store[head];
            bus.mc_addr  <= h_addr;
            bus.mc_wdata <= e_rs2[head];
            bus.mc_len   <= len_code(e_f3[head][1:0]);
          end
        end
        S_WAIT: begin
          if (clr_in && !e_store[head]) drop <= 1'b1;
          if (bus.mc_done) begin
            state      <= S_IDLE;
            drop       <= 1'b0;
            bus.mc_req <= 1'b0;
            bus.mc_we  <= 1'b0;
            if (!e_store[head] && !drop && !clr_in) begin
              bus.res_valid     <= 1'b1;
              bus.res_data      <= load_data;
              bus.res_rob_index <= e_rob[head];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_ooo_buffer.sv
// Directed bench for lsq_ooo_buffer: a table of speculative loads plus
// hand-written sequences for IO loads, snooping, full/wrap, flush and stall.
module tb_lsq_ooo_buffer;

  typedef struct {
    logic [3:0]  rob;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_len;
    logic [31:0] exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rdy, clr;
  int   total = 0;
  int   bad   = 0;

  lsq_ooo_buffer_if #(.ROB_W(4), .XLEN(32)) bus ();

  lsq_ooo_buffer #(
    .DEPTH(16), .ROB_W(4), .XLEN(32), .LOAD_SPEC(1'b1), .IO_BASE(32'h0003_0000)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clr_in(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0; bus.issue_rob_index = '0; bus.issue_is_store = 1'b0;
    bus.issue_funct3 = '0; bus.issue_rs1_val = '0; bus.issue_rs2_val = '0;
    bus.issue_rs1_dep = '0; bus.issue_rs2_dep = '0; bus.issue_imm = '0;
    bus.cdb0_valid = 1'b0; bus.cdb0_tag = '0; bus.cdb0_data = '0;
    bus.rob_commit_valid = 1'b0; bus.rob_commit_index = '0;
    bus.mc_done = 1'b0; bus.mc_rdata = '0;
  endtask

  task automatic set_issue(input logic [3:0] rob, input logic st, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] imm,
                           input logic [31:0] rs2, input logic [3:0] d2);
    bus.issue_valid = 1'b1; bus.issue_rob_index = rob; bus.issue_is_store = st;
    bus.issue_funct3 = f3; bus.issue_rs1_val = rs1; bus.issue_imm = imm;
    bus.issue_rs2_val = rs2; bus.issue_rs1_dep = '0; bus.issue_rs2_dep = d2;
  endtask

  task automatic issue(input logic [3:0] rob, input logic st, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic [3:0] d2);
    set_issue(rob, st, f3, rs1, imm, rs2, d2);
    tick();
    bus.issue_valid = 1'b0; bus.issue_rs2_dep = '0;
  endtask

  task automatic commit(input logic [3:0] rob);
    bus.rob_commit_valid = 1'b1; bus.rob_commit_index = rob;
    tick();
    bus.rob_commit_valid = 1'b0;
  endtask

  task automatic mem_done(input logic [31:0] rdata);
    bus.mc_done = 1'b1; bus.mc_rdata = rdata;
    tick();
    bus.mc_done = 1'b0;
  endtask

  task automatic wait_req(input string name, output int n);
    n = 0;
    while (!bus.mc_req && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (!bus.mc_req) begin
      bad++;
      $display("FAIL %s: mc_req never rose within 40 cycles", name);
      n = -1;
    end
  endtask

  task automatic no_req(input string name, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.mc_req || bus.res_valid) hits++;
    end
    check(name, 32'(hits), 32'd0);
  endtask

  task automatic io_load(input string name, input logic [3:0] rob, input logic [2:0] f3,
                         input logic [31:0] imm, input logic [31:0] rdata,
                         input logic [1:0] exp_len, input logic [31:0] exp_res);
    int n;
    issue(rob, 1'b0, f3, 32'h0003_0000, imm, 32'h0, 4'd0);
    no_req({name, "_hold"}, 4);
    commit(4'd2);
    no_req({name, "_wrong_commit"}, 3);
    commit(rob);
    wait_req({name, "_req"}, n);
    check({name, "_addr"}, bus.mc_addr, 32'h0003_0000 + imm);
    check({name, "_len"}, 32'(bus.mc_len), 32'(exp_len));
    mem_done(rdata);
    check({name, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check({name, "_res_data"}, bus.res_data, exp_res);
    check({name, "_res_rob"}, 32'(bus.res_rob_index), 32'(rob));
  endtask

  initial begin
    vec_t vecs[6];
    int n;
    logic [31:0] exp_a[16];
    logic [31:0] exp_w[16];

    vecs[0] = '{rob:4'd3, f3:3'b000, rs1:32'h100,  imm:32'h4,         rdata:32'h80,
                exp_addr:32'h104,   exp_len:2'b01, exp_res:32'hFFFF_FF80};
    vecs[1] = '{rob:4'd4, f3:3'b100, rs1:32'h200,  imm:32'hFFFF_FFFC, rdata:32'h1234_56F0,
                exp_addr:32'h1FC,   exp_len:2'b01, exp_res:32'h0000_00F0};
    vecs[2] = '{rob:4'd5, f3:3'b001, rs1:32'h1000, imm:32'h2,         rdata:32'h0000_9234,
                exp_addr:32'h1002,  exp_len:2'b10, exp_res:32'hFFFF_9234};
    vecs[3] = '{rob:4'd6, f3:3'b101, rs1:32'h0,    imm:32'h10,        rdata:32'hFFFF_7FFF,
                exp_addr:32'h10,    exp_len:2'b10, exp_res:32'h0000_7FFF};
    vecs[4] = '{rob:4'd7, f3:3'b010, rs1:32'h2FFFC, imm:32'h0,        rdata:32'hCAFE_F00D,
                exp_addr:32'h2FFFC, exp_len:2'b11, exp_res:32'hCAFE_F00D};
    vecs[5] = '{rob:4'd1, f3:3'b001, rs1:32'h40,   imm:32'h0,         rdata:32'hABCD_7FFF,
                exp_addr:32'h40,    exp_len:2'b10, exp_res:32'h0000_7FFF};

    // reset, with a flush request asserted at the same time
    idle_inputs();
    rst = 1'b1; clr = 1'b1; rdy = 1'b1;
    tick(); tick(); tick();
    check("rst_mc_req", 32'(bus.mc_req), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_full", 32'(bus.lsq_full), 32'd0);
    check("rst_mc_addr", bus.mc_addr, 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    rst = 1'b0; clr = 1'b0;
    tick();

    // speculative loads: dispatch one cycle after issue without a commit
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].rob, 1'b0, vecs[v].f3, vecs[v].rs1, vecs[v].imm, 32'h0, 4'd0);
      check($sformatf("v%0d_req_before", v), 32'(bus.mc_req), 32'd0);
      wait_req($sformatf("v%0d_req", v), n);
      check($sformatf("v%0d_latency", v), 32'(n), 32'd1);
      check($sformatf("v%0d_we", v), 32'(bus.mc_we), 32'd0);
      check($sformatf("v%0d_addr", v), bus.mc_addr, vecs[v].exp_addr);
      check($sformatf("v%0d_len", v), 32'(bus.mc_len), 32'(vecs[v].exp_len));
      mem_done(vecs[v].rdata);
      check($sformatf("v%0d_req_drop", v), 32'(bus.mc_req), 32'd0);
      check($sformatf("v%0d_res_valid", v), 32'(bus.res_valid), 32'd1);
      check($sformatf("v%0d_res_data", v), bus.res_data, vecs[v].exp_res);
      check($sformatf("v%0d_res_rob", v), 32'(bus.res_rob_index), 32'(vecs[v].rob));
      tick();
      check($sformatf("v%0d_res_pulse", v), 32'(bus.res_valid), 32'd0);
    end

    // IO loads wait for their own commit
    io_load("io_lw", 4'd8, 3'b010, 32'h4, 32'h1122_3344, 2'b11, 32'h1122_3344);
    io_load("io_lhu", 4'd9, 3'b101, 32'h10, 32'h0000_8001, 2'b10, 32'h0000_8001);

    // issue-cycle bypass of the store data from cdb0
    bus.cdb0_valid = 1'b1; bus.cdb0_tag = 4'd5; bus.cdb0_data = 32'hDEAD_BEEF;
    issue(4'd10, 1'b1, 3'b010, 32'h400, 32'h8, 32'h0, 4'd5);
    bus.cdb0_valid = 1'b0;
    no_req("byp_uncommitted", 3);
    commit(4'd10);
    wait_req("byp_req", n);
    check("byp_we", 32'(bus.mc_we), 32'd1);
    check("byp_addr", bus.mc_addr, 32'h408);
    check("byp_wdata", bus.mc_wdata, 32'hDEAD_BEEF);
    check("byp_len", 32'(bus.mc_len), 32'd3);
    mem_done(32'hFFFF_FFFF);
    check("byp_no_res", 32'(bus.res_valid), 32'd0);
    no_req("byp_quiet", 3);

    // late snoop: committed store waits for its data on cdb0
    issue(4'd11, 1'b1, 3'b000, 32'h440, 32'h0, 32'h0, 4'd6);
    commit(4'd11);
    no_req("snoop_wait_dep", 3);
    bus.cdb0_valid = 1'b1; bus.cdb0_tag = 4'd6; bus.cdb0_data = 32'h0BAD_F00D;
    tick();
    bus.cdb0_valid = 1'b0;
    wait_req("snoop_req", n);
    check("snoop_latency", 32'(n), 32'd1);
    check("snoop_wdata", bus.mc_wdata, 32'h0BAD_F00D);
    check("snoop_len", 32'(bus.mc_len), 32'd1);
    mem_done(32'h0);
    check("snoop_no_res", 32'(bus.res_valid), 32'd0);

    // fill all 16 entries, reject a 17th, drain 3, refill across the wrap
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), 1'b1, 3'b010, 32'h1000 + 32'(4 * i), 32'h0, 32'(i), 4'd0);
      check($sformatf("fill_full_%0d", i), 32'(bus.lsq_full), 32'(i == 15));
    end
    issue(4'd0, 1'b1, 3'b010, 32'h9990, 32'h0, 32'h9, 4'd0);
    check("full_reject", 32'(bus.lsq_full), 32'd1);
    commit(4'd0); commit(4'd1); commit(4'd2);
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("drain_req_%0d", k), n);
      check($sformatf("drain_addr_%0d", k), bus.mc_addr, 32'h1000 + 32'(4 * k));
      mem_done(32'h0);
    end
    check("drain_not_full", 32'(bus.lsq_full), 32'd0);
    for (int k = 0; k < 3; k++) issue(4'(k), 1'b1, 3'b010, 32'h2000 + 32'(4 * k), 32'h0, 32'h100 + 32'(k), 4'd0);
    check("refill_full", 32'(bus.lsq_full), 32'd1);
    for (int i = 3; i < 16; i++) commit(4'(i));
    for (int k = 0; k < 3; k++) commit(4'(k));
    for (int i = 0; i < 13; i++) begin
      exp_a[i] = 32'h1000 + 32'(4 * (i + 3));
      exp_w[i] = 32'(i + 3);
    end
    for (int k = 0; k < 3; k++) begin
      exp_a[13 + k] = 32'h2000 + 32'(4 * k);
      exp_w[13 + k] = 32'h100 + 32'(k);
    end
    for (int i = 0; i < 16; i++) begin
      wait_req($sformatf("wrap_req_%0d", i), n);
      check($sformatf("wrap_addr_%0d", i), bus.mc_addr, exp_a[i]);
      check($sformatf("wrap_wdata_%0d", i), bus.mc_wdata, exp_w[i]);
      mem_done(32'h0);
    end
    no_req("wrap_empty", 5);

    // flush: in-flight load dropped, committed stores survive, rest discarded
    issue(4'd1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 4'd0);
    issue(4'd2, 1'b1, 3'b010, 32'h600, 32'h0, 32'h22, 4'd0);
    issue(4'd3, 1'b1, 3'b010, 32'h604, 32'h0, 32'h33, 4'd0);
    issue(4'd4, 1'b0, 3'b010, 32'h700, 32'h0, 32'h0, 4'd0);
    commit(4'd1);
    commit(4'd2);
    clr = 1'b1;
    bus.rob_commit_valid = 1'b1; bus.rob_commit_index = 4'd3;
    set_issue(4'd5, 1'b0, 3'b010, 32'h900, 32'h0, 32'h0, 4'd0);
    tick();
    clr = 1'b0; bus.rob_commit_valid = 1'b0; bus.issue_valid = 1'b0;
    check("flush_inflight_req", 32'(bus.mc_req), 32'd1);
    check("flush_inflight_addr", bus.mc_addr, 32'h500);
    mem_done(32'h1234_5678);
    check("flush_load_dropped", 32'(bus.res_valid), 32'd0);
    wait_req("flush_st0_req", n);
    check("flush_st0_addr", bus.mc_addr, 32'h600);
    check("flush_st0_wdata", bus.mc_wdata, 32'h22);
    mem_done(32'h0);
    wait_req("flush_st1_req", n);
    check("flush_st1_addr", bus.mc_addr, 32'h604);
    check("flush_st1_wdata", bus.mc_wdata, 32'h33);
    mem_done(32'h0);
    no_req("flush_rest_gone", 10);

    // rdy_in low freezes WAIT and ignores mc_done and issue
    issue(4'd6, 1'b0, 3'b000, 32'h800, 32'h0, 32'h0, 4'd0);
    wait_req("stall_req", n);
    rdy = 1'b0; bus.mc_done = 1'b1; bus.mc_rdata = 32'h7F;
    set_issue(4'd7, 1'b0, 3'b010, 32'hA00, 32'h0, 32'h0, 4'd0);
    tick(); tick();
    check("stall_req_held", 32'(bus.mc_req), 32'd1);
    check("stall_addr_held", bus.mc_addr, 32'h800);
    check("stall_no_res", 32'(bus.res_valid), 32'd0);
    bus.mc_done = 1'b0; bus.issue_valid = 1'b0; rdy = 1'b1;
    tick();
    check("stall_resume_req", 32'(bus.mc_req), 32'd1);
    mem_done(32'hFF);
    check("stall_res_valid", 32'(bus.res_valid), 32'd1);
    check("stall_res_data", bus.res_data, 32'hFFFF_FFFF);
    check("stall_res_rob", 32'(bus.res_rob_index), 32'd6);
    no_req("stall_issue_ignored", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
